vec_checker: RTL and testbench

//  Synthesizable, parametrised self-checking vector sequencer for combinational or multi-cycle DUTs
//  (ALU decoder, main decoder, ALU). Streams stored vectors to the DUT, waits a programmable settle

---
 rtl/wjbot_riscv.sv | 33 +++
 rtl/sig_hash.sv | 44 ++++
 rtl/vec_checker.sv | 194 +++++++++++++++++++
 tb/tb_vec_checker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wjbot_riscv.sv
// Shared types and helpers for the vec_checker vector sequencer.
//  vc_state_t : sequencer states
//  VC_CNT_W   : width of the vector / error counters
//  sig_step   : one signature update step on a HASH_W-bit register (HASH_W <= SIG_MAX_W)
package wjbot_riscv;

   localparam int unsigned VC_CNT_W  = 32;
   localparam int unsigned SIG_MAX_W = 32;

   typedef enum logic [2:0] {
      VC_IDLE,
      VC_FETCH,
      VC_SETTLE,
      VC_CHECK,
      VC_DONE
   } vc_state_t;

   // h = hash ^ data; result = {h[hw-2:0], h[hw-1] ^ h[hw-2]}; bits >= hw stay zero
   function automatic logic [SIG_MAX_W-1:0] sig_step(input logic [SIG_MAX_W-1:0] hash,
                                                    input logic [SIG_MAX_W-1:0] data,
                                                    input int unsigned          hw);
      logic [SIG_MAX_W-1:0] h;
      logic [SIG_MAX_W-1:0] r;
      h = hash ^ data;
      r = '0;
      for (int i = 1; i < int'(SIG_MAX_W); i++) begin
         if (i < int'(hw)) r[i] = h[i-1];
      end
      r[0] = h[5'(hw - 1)] ^ h[5'(hw - 2)];
      return r;
   endfunction

endpackage

// File: rtl/sig_hash.sv
// Rolling signature register over sampled DUT outputs.
//  i_clk, i_reset_n : clock, synchronous active-low reset
//  i_clr            : clear signature (start of a run)
//  i_en             : fold i_din into the signature this cycle
//  i_din [OUT_W]    : sampled DUT output
//  o_hash [HASH_W]  : current signature
module sig_hash
   import wjbot_riscv::*;
#(
   parameter int unsigned HASH_W = 7,
   parameter int unsigned OUT_W  = 3
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic [OUT_W-1:0]  i_din,
   output logic [HASH_W-1:0] o_hash
);

   localparam int unsigned IW = (HASH_W > 1) ? $clog2(HASH_W) : 1;

   logic [HASH_W-1:0] r_hash;
   logic [HASH_W-1:0] w_fold;
   logic [HASH_W-1:0] w_next;

   // Zero-extend narrow outputs; XOR-fold wide ones into HASH_W-wide slices
   always_comb begin
      w_fold = '0;
      for (int i = 0; i < int'(OUT_W); i++) begin
         w_fold[IW'(i % int'(HASH_W))] = w_fold[IW'(i % int'(HASH_W))] ^ i_din[i];
      end
   end

   assign w_next = HASH_W'(sig_step(SIG_MAX_W'(r_hash), SIG_MAX_W'(w_fold), HASH_W));

   always_ff @(posedge i_clk) begin
      if (!i_reset_n || i_clr) r_hash <= '0;
      else if (i_en)           r_hash <= w_next;
   end

   assign o_hash = r_hash;

endmodule

// File: rtl/vec_checker.sv
// Self-checking vector sequencer: streams stored stimulus to a DUT, waits SETTLE cycles,
// compares the masked response and accumulates error count and a rolling signature.
//  i_clk, i_reset_n        : clock, synchronous active-low reset
//  i_wr_en/addr/data       : vector memory write {valid, stim, expected, mask}; honoured only idle/done
//  i_start                 : begin a run from entry 0 (ignored while busy)
//  o_dut_in / i_dut_out    : stimulus to and response from the DUT
//  o_busy, o_done          : run in progress / run finished (held until next start or reset)
//  o_vec_count, o_err_count: saturating counters of checked / mismatching vectors
//  o_hash                  : signature of all sampled responses
// Optional macro VEC_CHECKER_ERRLOG_EN adds o_first_err_idx/obs/vld (first mismatch of a run).
module vec_checker
   import wjbot_riscv::*;
#(
   parameter int unsigned IN_W   = 7,
   parameter int unsigned OUT_W  = 3,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned HASH_W = 7,
   parameter int unsigned SETTLE = 1
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic                       i_wr_en,
   input  logic [$clog2(DEPTH)-1:0]   i_wr_addr,
   input  logic [IN_W+2*OUT_W:0]      i_wr_data,
   input  logic                       i_start,
   output logic [IN_W-1:0]            o_dut_in,
   input  logic [OUT_W-1:0]           i_dut_out,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [VC_CNT_W-1:0]        o_vec_count,
   output logic [VC_CNT_W-1:0]        o_err_count,
   output logic [HASH_W-1:0]          o_hash
`ifdef VEC_CHECKER_ERRLOG_EN
   ,
   output logic [$clog2(DEPTH)-1:0]   o_first_err_idx,
   output logic [OUT_W-1:0]           o_first_err_obs,
   output logic                       o_first_err_vld
`endif
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned EW  = 1 + IN_W + 2 * OUT_W;
   localparam int unsigned SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   vc_state_t           r_state;
   logic [AW-1:0]       r_idx;
   logic                r_fetch_ph;
   logic [SCW-1:0]      r_settle_cnt;
   logic [IN_W-1:0]     r_dut_in;
   logic                r_busy;
   logic                r_done;
   logic [VC_CNT_W-1:0] r_vec_cnt;
   logic [VC_CNT_W-1:0] r_err_cnt;
   logic [EW-1:0]       r_mem [DEPTH];
   logic [EW-1:0]       r_rd_data;

   logic                w_vld;
   logic [IN_W-1:0]     w_stim;
   logic [OUT_W-1:0]    w_exp;
   logic [OUT_W-1:0]    w_mask;
   logic                w_mis;
   logic                w_idle;
   logic                w_start_acc;
   logic                w_check;

   assign w_vld       = r_rd_data[EW-1];
   assign w_stim      = r_rd_data[EW-2 -: IN_W];
   assign w_exp       = r_rd_data[2*OUT_W-1 -: OUT_W];
   assign w_mask      = r_rd_data[OUT_W-1:0];
   assign w_mis       = |((i_dut_out ^ w_exp) & w_mask);
   assign w_idle      = (r_state == VC_IDLE) || (r_state == VC_DONE);
   assign w_start_acc = i_start && w_idle;
   assign w_check     = (r_state == VC_CHECK);

   // Vector memory: writes only outside a run; read address is r_idx, data valid one cycle later
   always_ff @(posedge i_clk) begin
      if (i_wr_en && w_idle) r_mem[i_wr_addr] <= i_wr_data;
      r_rd_data <= r_mem[r_idx];
   end

   // Sequencer
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state      <= VC_IDLE;
         r_idx        <= '0;
         r_fetch_ph   <= 1'b0;
         r_settle_cnt <= '0;
         r_dut_in     <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_vec_cnt    <= '0;
         r_err_cnt    <= '0;
      end else begin
         case (r_state)
            VC_IDLE, VC_DONE: begin
               if (i_start) begin
                  r_state    <= VC_FETCH;
                  r_idx      <= '0;
                  r_fetch_ph <= 1'b0;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_vec_cnt  <= '0;
                  r_err_cnt  <= '0;
               end
            end
            VC_FETCH: begin
               // Phase 0 presents the address, phase 1 consumes the read data
               if (!r_fetch_ph) begin
                  r_fetch_ph <= 1'b1;
               end else begin
                  r_fetch_ph <= 1'b0;
                  if (!w_vld) begin
                     r_state <= VC_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_dut_in     <= w_stim;
                     r_settle_cnt <= '0;
                     r_state      <= (SETTLE > 1) ? VC_SETTLE : VC_CHECK;
                  end
               end
            end
            VC_SETTLE: begin
               if (r_settle_cnt == SCW'(SETTLE - 2)) r_state <= VC_CHECK;
               else                                 r_settle_cnt <= r_settle_cnt + SCW'(1);
            end
            VC_CHECK: begin
               if (r_vec_cnt != '1)           r_vec_cnt <= r_vec_cnt + VC_CNT_W'(1);
               if (w_mis && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + VC_CNT_W'(1);
               // Last memory entry ends the run instead of wrapping to 0
               if (r_idx == AW'(DEPTH - 1)) begin
                  r_state <= VC_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_idx   <= r_idx + AW'(1);
                  r_state <= VC_FETCH;
               end
            end
            default: r_state <= VC_IDLE;
         endcase
      end
   end

   sig_hash #(
      .HASH_W (HASH_W),
      .OUT_W  (OUT_W)
   ) u_sig_hash (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clr     (w_start_acc),
      .i_en      (w_check),
      .i_din     (i_dut_out),
      .o_hash    (o_hash)
   );

   assign o_dut_in    = r_dut_in;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_vec_count = r_vec_cnt;
   assign o_err_count = r_err_cnt;

`ifdef VEC_CHECKER_ERRLOG_EN
   logic [AW-1:0]    r_fe_idx;
   logic [OUT_W-1:0] r_fe_obs;
   logic             r_fe_vld;

   // First mismatch of the current run
   always_ff @(posedge i_clk) begin
      if (!i_reset_n || w_start_acc) begin
         r_fe_idx <= '0;
         r_fe_obs <= '0;
         r_fe_vld <= 1'b0;
      end else if (w_check && w_mis && !r_fe_vld) begin
         r_fe_idx <= r_idx;
         r_fe_obs <= i_dut_out;
         r_fe_vld <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge i_clk) begin
      if (i_reset_n && w_check && w_mis)
         $display("vec_checker: mismatch idx=%0d stim=%0h observed=%0h expected=%0h",
                  r_idx, w_stim, i_dut_out, w_exp);
   end
`endif

   assign o_first_err_idx = r_fe_idx;
   assign o_first_err_obs = r_fe_obs;
   assign o_first_err_vld = r_fe_vld;
`endif

endmodule

// File: tb/tb_vec_checker.sv
// Bench for vec_checker: three instances (A: default params with a wire DUT,
// B: DEPTH=4 SETTLE=4 and C: DEPTH=4 SETTLE=2, both with a 3-cycle pipeline DUT).
// Run results are queued on start and compared by a monitor on each rising done.
module tb_vec_checker;

   typedef struct {
      int         inst;
      int         vec;
      int         err;
      logic [6:0] hash;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [13:0] wr_data;
   logic [2:0]  start;
   logic [6:0]  din [3];
   logic [2:0]  dout [3];
   logic [2:0]  busy;
   logic [2:0]  done;
   logic [31:0] vec [3];
   logic [31:0] err [3];
   logic [6:0]  hash [3];

   logic [2:0]  pb1 = '0, pb2 = '0, pb3 = '0;
   logic [2:0]  pc1 = '0, pc2 = '0, pc3 = '0;

   always #5 clk = ~clk;

   // DUT models: A is a plain wire, B and C a 3-stage pipeline
   assign dout[0] = din[0][2:0];
   always @(posedge clk) begin
      pb1 <= din[1][2:0]; pb2 <= pb1; pb3 <= pb2;
      pc1 <= din[2][2:0]; pc2 <= pc1; pc3 <= pc2;
   end
   assign dout[1] = pb3;
   assign dout[2] = pc3;

   vec_checker u_a (
      .i_clk(clk), .i_reset_n(reset_n), .i_wr_en(wr_en[0]), .i_wr_addr(wr_addr),
      .i_wr_data(wr_data), .i_start(start[0]), .o_dut_in(din[0]), .i_dut_out(dout[0]),
      .o_busy(busy[0]), .o_done(done[0]), .o_vec_count(vec[0]), .o_err_count(err[0]),
      .o_hash(hash[0]));

   vec_checker #(.DEPTH(4), .SETTLE(4)) u_b (
      .i_clk(clk), .i_reset_n(reset_n), .i_wr_en(wr_en[1]), .i_wr_addr(wr_addr[1:0]),
      .i_wr_data(wr_data), .i_start(start[1]), .o_dut_in(din[1]), .i_dut_out(dout[1]),
      .o_busy(busy[1]), .o_done(done[1]), .o_vec_count(vec[1]), .o_err_count(err[1]),
      .o_hash(hash[1]));

   vec_checker #(.DEPTH(4), .SETTLE(2)) u_c (
      .i_clk(clk), .i_reset_n(reset_n), .i_wr_en(wr_en[2]), .i_wr_addr(wr_addr[1:0]),
      .i_wr_data(wr_data), .i_start(start[2]), .o_dut_in(din[2]), .i_dut_out(dout[2]),
      .o_busy(busy[2]), .o_done(done[2]), .o_vec_count(vec[2]), .o_err_count(err[2]),
      .o_hash(hash[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [13:0] ent(input logic v, input logic [6:0] s,
                                       input logic [2:0] e, input logic [2:0] m);
      return {v, s, e, m};
   endfunction

   // Reference signature step for HASH_W=7, OUT_W=3
   function automatic logic [6:0] hstep(input logic [6:0] h0, input logic [2:0] obs);
      logic [6:0] h;
      h = h0 ^ {4'b0000, obs};
      return {h[5:0], h[6] ^ h[5]};
   endfunction

   task automatic wr(input logic [2:0] en, input int addr, input logic [13:0] d);
      @(negedge clk);
      wr_en   = en;
      wr_addr = 10'(addr);
      wr_data = d;
      @(negedge clk);
      wr_en   = '0;
   endtask

   task automatic pulse_start(input int i);
      @(negedge clk);
      start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
   endtask

   task automatic push(input int i, input int v, input int e, input logic [6:0] h);
      exp_t x;
      x.inst = i; x.vec = v; x.err = e; x.hash = h;
      sb.push_back(x);
   endtask

   task automatic wait_done(input int i);
      int n;
      n = 0;
      while (!done[i] && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!done[i]) begin
         checks++;
         failures++;
         $display("FAIL done_timeout inst=%0d actual=0 expected=1", i);
      end
      @(negedge clk);
   endtask

   // Scoreboard monitor: each rising done pops one expected run result
   logic [2:0] done_q = '0;
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (done[i] && !done_q[i]) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected_done inst=%0d actual=done expected=none", i);
            end else begin
               exp_t x;
               x = sb.pop_front();
               chk("sb_inst", 32'(i), 32'(x.inst));
               chk("sb_vec_count", vec[i], 32'(x.vec));
               chk("sb_err_count", err[i], 32'(x.err));
               chk("sb_hash", 32'(hash[i]), 32'(x.hash));
            end
         end
      end
      done_q = done;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int         nchg;
      int         tch [4];
      logic [31:0] last;
      logic [6:0]  hm;

      reset_n = 1'b0;
      wr_en   = '0;
      wr_addr = '0;
      wr_data = '0;
      start   = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      chk("rst_busy",  32'(busy[0]), 32'd0);
      chk("rst_done",  32'(done[0]), 32'd0);
      chk("rst_vec",   vec[0], 32'd0);
      chk("rst_err",   err[0], 32'd0);
      chk("rst_hash",  32'(hash[0]), 32'd0);
      chk("rst_dutin", 32'(din[0]), 32'd0);

      // Run 1: three matching vectors, signature 0x02 -> 0x00 -> 0x06
      wr(3'b001, 0, ent(1'b1, 7'd1, 3'd1, 3'b111));
      wr(3'b001, 1, ent(1'b1, 7'd2, 3'd2, 3'b111));
      wr(3'b001, 2, ent(1'b1, 7'd3, 3'd3, 3'b111));
      wr(3'b001, 3, ent(1'b0, 7'd0, 3'd0, 3'b000));
      push(0, 3, 0, 7'h06);
      pulse_start(0);
      nchg = 0;
      last = vec[0];
      for (int c = 0; c < 200 && !done[0]; c++) begin
         if (c == 4) start[0] = 1'b1;   // start while busy must be ignored
         if (c == 5) start[0] = 1'b0;
         @(negedge clk);
         if (vec[0] != last) begin
            if (nchg < 4) tch[nchg] = c;
            nchg++;
            last = vec[0];
         end
      end
      start[0] = 1'b0;
      chk("run1_done", 32'(done[0]), 32'd1);
      chk("run1_vec_steps", 32'(nchg), 32'd3);
      if (nchg >= 3) begin
         chk("run1_latency_v2", 32'(tch[1] - tch[0]), 32'd3);
         chk("run1_latency_v3", 32'(tch[2] - tch[1]), 32'd3);
      end
      @(negedge clk);
      chk("run1_dutin_hold", 32'(din[0]), 32'd3);

      // Run 2: entry 1 expects 101, wire DUT returns 100 -> one error
      wr(3'b001, 1, ent(1'b1, 7'd4, 3'b101, 3'b111));
      hm = hstep(hstep(hstep(7'h00, 3'd1), 3'd4), 3'd3);
      push(0, 3, 1, hm);
      pulse_start(0);
      wait_done(0);

      // Run 3: masking off bit 0 hides the difference; write during the run is dropped
      wr(3'b001, 1, ent(1'b1, 7'd4, 3'b101, 3'b110));
      push(0, 3, 0, hm);
      pulse_start(0);
      wr(3'b001, 0, ent(1'b1, 7'd1, 3'd0, 3'b111));
      wait_done(0);

      // B and C share four valid entries 1..4
      for (int k = 0; k < 4; k++)
         wr(3'b110, k, ent(1'b1, 7'(k + 1), 3'(k + 1), 3'b111));

      // Reset during SETTLE of B's second vector
      pulse_start(1);
      for (int n = 0; n < 100 && vec[1] != 32'd1; n++) @(negedge clk);
      chk("b_reached_v1", vec[1], 32'd1);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("midrst_busy", 32'(busy[1]), 32'd0);
      chk("midrst_done", 32'(done[1]), 32'd0);
      chk("midrst_vec",  vec[1], 32'd0);
      chk("midrst_err",  err[1], 32'd0);
      chk("midrst_hash", 32'(hash[1]), 32'd0);
      chk("midrst_a_done", 32'(done[0]), 32'd0);

      // B rerun: SETTLE=4 covers the pipeline, all four entries end the run without wrap
      push(1, 4, 0, 7'h04);
      pulse_start(1);
      wait_done(1);
      chk("b_dutin_hold", 32'(din[1]), 32'd4);

      // C: SETTLE=2 samples the previous vector's response -> every vector mismatches
      hm = hstep(hstep(hstep(hstep(7'h00, 3'd0), 3'd1), 3'd2), 3'd3);
      push(2, 4, 4, hm);
      pulse_start(2);
      wait_done(2);

      // A after reset: memory retained, dropped write left entry 0 intact
      hm = hstep(hstep(hstep(7'h00, 3'd1), 3'd4), 3'd3);
      push(0, 3, 0, hm);
      pulse_start(0);
      wait_done(0);

      // start and reset in the same cycle: reset wins
      @(negedge clk);
      start[0] = 1'b1;
      reset_n  = 1'b0;
      @(negedge clk);
      start[0] = 1'b0;
      reset_n  = 1'b1;
      chk("rst_start_busy", 32'(busy[0]), 32'd0);
      chk("rst_start_vec",  vec[0], 32'd0);
      @(negedge clk);
      chk("rst_start_idle", 32'(busy[0]), 32'd0);

      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
